// File: rtl/mdu_arb.sv
// Two-requester arbiter in front of one shared multi-cycle divider.
// Grants in IDLE (round-robin on contention), issues one start pulse, then routes the result back to the owner.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

module mdu_arb #(
    parameter int WIDTH = `CPU_WIDTH,
    parameter int NREQ  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,

    input  logic [NREQ-1:0]         i_req_valid,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic [NREQ-1:0]         i_req_divw,
    input  logic [NREQ-1:0]         i_req_signed,
    input  logic [NREQ*WIDTH-1:0]   i_req_dividend,
    input  logic [NREQ*WIDTH-1:0]   i_req_divisor,

    output logic                    o_div_start,
    input  logic                    i_div_busy,
    input  logic                    i_div_end_valid,
    output logic                    o_div_end_ready,
    output logic                    o_div_divw,
    output logic                    o_div_signed,
    output logic [WIDTH-1:0]        o_div_dividend,
    output logic [WIDTH-1:0]        o_div_divisor,
    input  logic [WIDTH-1:0]        i_div_quotient,
    input  logic [WIDTH-1:0]        i_div_remainder,

    output logic [NREQ-1:0]         o_rsp_valid,
    input  logic [NREQ-1:0]         i_rsp_ready,
    output logic [WIDTH-1:0]        o_rsp_quotient,
    output logic [WIDTH-1:0]        o_rsp_remainder
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             owner_q, owner_d;
    logic             divw_q, divw_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;

    logic             grant;
    logic             in_idle;
    logic             in_issue;
    logic             in_wait;
    logic             any_req;

    assign in_idle  = (state_q == S_IDLE);
    assign in_issue = (state_q == S_ISSUE);
    assign in_wait  = (state_q == S_WAIT);
    assign any_req  = |i_req_valid;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant = rr_ptr_q;
        case (i_req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = rr_ptr_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        divw_d     = divw_q;
        signed_d   = signed_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;

        if (i_flush) begin
            state_d    = S_IDLE;
            owner_d    = 1'b0;
            divw_d     = 1'b0;
            signed_d   = 1'b0;
            dividend_d = '0;
            divisor_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        state_d    = S_ISSUE;
                        owner_d    = grant;
                        divw_d     = i_req_divw[grant];
                        signed_d   = i_req_signed[grant];
                        dividend_d = grant ? i_req_dividend[WIDTH +: WIDTH]
                                           : i_req_dividend[0 +: WIDTH];
                        divisor_d  = grant ? i_req_divisor[WIDTH +: WIDTH]
                                           : i_req_divisor[0 +: WIDTH];
                    end
                end
                S_ISSUE: begin
                    if (!i_div_busy) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_div_end_valid && i_rsp_ready[owner_q]) begin
                        state_d    = S_IDLE;
                        rr_ptr_d   = ~owner_q;
                        owner_d    = 1'b0;
                        divw_d     = 1'b0;
                        signed_d   = 1'b0;
                        dividend_d = '0;
                        divisor_d  = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= 1'b0;
            owner_q    <= 1'b0;
            divw_q     <= 1'b0;
            signed_q   <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            divw_q     <= divw_d;
            signed_q   <= signed_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
        end
    end

    // Ready is combinational from the request, so it must be masked during reset.
    always_comb begin
        o_req_ready = '0;
        if (i_rst_n && in_idle && !i_flush && any_req) begin
            o_req_ready[grant] = 1'b1;
        end
    end

    assign o_div_start    = in_issue && !i_div_busy && !i_flush;
    assign o_div_divw     = divw_q;
    assign o_div_signed   = signed_q;
    assign o_div_dividend = dividend_q;
    assign o_div_divisor  = divisor_q;

    always_comb begin
        o_rsp_valid = '0;
        if (in_wait && !i_flush) begin
            o_rsp_valid[owner_q] = i_div_end_valid;
        end
    end

    assign o_div_end_ready = in_wait && !i_flush && i_rsp_ready[owner_q];
    assign o_rsp_quotient  = in_wait ? i_div_quotient  : '0;
    assign o_rsp_remainder = in_wait ? i_div_remainder : '0;

endmodule

// File: tb/tb_mdu_arb.sv
// Directed vector bench for mdu_arb: a cycle table walks grant, issue, stall, back-pressure and flush cases;
// a hand-written sequence covers asynchronous reset in the middle of an operation.
module tb_mdu_arb;

    localparam logic [63:0] D0 = 64'd100;
    localparam logic [63:0] S0 = 64'd7;
    localparam logic [63:0] Q0 = 64'd14;
    localparam logic [63:0] R0 = 64'd2;
    localparam logic [63:0] D1 = 64'hFFFF_FFFF_FFFF_FFF7;
    localparam logic [63:0] S1 = 64'd2;
    localparam logic [63:0] Q1 = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] R1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_divw;
    logic [1:0]   req_signed;
    logic [127:0] req_dividend;
    logic [127:0] req_divisor;
    logic         div_start;
    logic         div_busy;
    logic         div_end_valid;
    logic         div_end_ready;
    logic         div_divw;
    logic         div_signed;
    logic [63:0]  div_dividend;
    logic [63:0]  div_divisor;
    logic [63:0]  div_quotient;
    logic [63:0]  div_remainder;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [63:0]  rsp_quotient;
    logic [63:0]  rsp_remainder;

    int n_vec;
    int n_bad;

    mdu_arb dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_divw      (req_divw),
        .i_req_signed    (req_signed),
        .i_req_dividend  (req_dividend),
        .i_req_divisor   (req_divisor),
        .o_div_start     (div_start),
        .i_div_busy      (div_busy),
        .i_div_end_valid (div_end_valid),
        .o_div_end_ready (div_end_ready),
        .o_div_divw      (div_divw),
        .o_div_signed    (div_signed),
        .o_div_dividend  (div_dividend),
        .o_div_divisor   (div_divisor),
        .i_div_quotient  (div_quotient),
        .i_div_remainder (div_remainder),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_rsp_quotient  (rsp_quotient),
        .o_rsp_remainder (rsp_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic        fl;
        logic        busy;
        logic        endv;
        logic [1:0]  rspr;
        logic [63:0] q;
        logic [63:0] r;
        logic [1:0]  e_ready;
        logic        e_start;
        logic [1:0]  e_rspv;
        logic        e_endr;
        logic [1:0]  e_ctl;
        logic [63:0] e_dvd;
        logic [63:0] e_dvs;
        logic [63:0] e_q;
        logic [63:0] e_r;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] v, input logic fl, input logic bz, input logic ev,
                       input logic [1:0] rr, input logic [63:0] q, input logic [63:0] r,
                       input logic [1:0] e_rdy, input logic e_st, input logic [1:0] e_rv,
                       input logic e_er, input logic [1:0] e_ctl, input logic [63:0] e_dvd,
                       input logic [63:0] e_dvs, input logic [63:0] e_q, input logic [63:0] e_r);
        vec_t t;
        t.valid = v;     t.fl = fl;        t.busy = bz;     t.endv = ev;
        t.rspr = rr;     t.q = q;          t.r = r;
        t.e_ready = e_rdy; t.e_start = e_st; t.e_rspv = e_rv; t.e_endr = e_er;
        t.e_ctl = e_ctl; t.e_dvd = e_dvd;  t.e_dvs = e_dvs;
        t.e_q = e_q;     t.e_r = e_r;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t t);
        n_vec++;
        chk({tag, " req_ready"},    64'(req_ready),           64'(t.e_ready));
        chk({tag, " div_start"},    64'(div_start),           64'(t.e_start));
        chk({tag, " rsp_valid"},    64'(rsp_valid),           64'(t.e_rspv));
        chk({tag, " div_end_ready"}, 64'(div_end_ready),      64'(t.e_endr));
        chk({tag, " div_ctl"},      64'({div_divw, div_signed}), 64'(t.e_ctl));
        chk({tag, " div_dividend"}, div_dividend,             t.e_dvd);
        chk({tag, " div_divisor"},  div_divisor,              t.e_dvs);
        chk({tag, " rsp_quotient"}, rsp_quotient,             t.e_q);
        chk({tag, " rsp_remainder"}, rsp_remainder,           t.e_r);
    endtask

    task automatic drive(input vec_t t);
        req_valid     = t.valid;
        flush         = t.fl;
        div_busy      = t.busy;
        div_end_valid = t.endv;
        rsp_ready     = t.rspr;
        div_quotient  = t.q;
        div_remainder = t.r;
    endtask

    vec_t idle0;

    initial begin
        n_vec = 0;
        n_bad = 0;

        // valid fl bz ev rspr q r | ready start rspv endr ctl dvd dvs q r
        add(2'b11, 0, 0, 0, 2'b00, 0,  0,  2'b01, 0, 2'b00, 0, 2'b00, 0,  0,  0,  0);
        add(2'b11, 0, 0, 0, 2'b00, Q0, R0, 2'b00, 1, 2'b00, 0, 2'b01, D0, S0, 0,  0);
        add(2'b11, 0, 0, 1, 2'b11, Q0, R0, 2'b00, 0, 2'b01, 1, 2'b01, D0, S0, Q0, R0);
        add(2'b11, 0, 0, 0, 2'b00, 0,  0,  2'b10, 0, 2'b00, 0, 2'b00, 0,  0,  0,  0);
        for (int i = 0; i < 5; i++)
            add(2'b00, 0, 1, 0, 2'b00, Q1, R1, 2'b00, 0, 2'b00, 0, 2'b11, D1, S1, 0, 0);
        add(2'b00, 0, 0, 0, 2'b00, 0,  0,  2'b00, 1, 2'b00, 0, 2'b11, D1, S1, 0,  0);
        for (int i = 0; i < 3; i++)
            add(2'b00, 0, 0, 1, 2'b00, Q1, R1, 2'b00, 0, 2'b10, 0, 2'b11, D1, S1, Q1, R1);
        add(2'b00, 0, 0, 1, 2'b10, Q1, R1, 2'b00, 0, 2'b10, 1, 2'b11, D1, S1, Q1, R1);
        add(2'b01, 0, 0, 0, 2'b00, 0,  0,  2'b01, 0, 2'b00, 0, 2'b00, 0,  0,  0,  0);
        add(2'b00, 0, 0, 0, 2'b00, 0,  0,  2'b00, 1, 2'b00, 0, 2'b01, D0, S0, 0,  0);
        // Flush beats a completing response: nothing returned, pointer untouched.
        add(2'b00, 1, 0, 1, 2'b11, Q0, R0, 2'b00, 0, 2'b00, 0, 2'b01, D0, S0, Q0, R0);
        add(2'b11, 0, 0, 0, 2'b00, 0,  0,  2'b01, 0, 2'b00, 0, 2'b00, 0,  0,  0,  0);
        add(2'b11, 1, 0, 0, 2'b00, 0,  0,  2'b00, 0, 2'b00, 0, 2'b01, D0, S0, 0,  0);
        add(2'b10, 0, 0, 0, 2'b00, 0,  0,  2'b10, 0, 2'b00, 0, 2'b00, 0,  0,  0,  0);
        add(2'b00, 0, 0, 0, 2'b00, 0,  0,  2'b00, 1, 2'b00, 0, 2'b11, D1, S1, 0,  0);
        add(2'b11, 1, 0, 0, 2'b00, 0,  0,  2'b00, 0, 2'b00, 0, 2'b11, D1, S1, 0,  0);
        add(2'b11, 1, 0, 0, 2'b00, 0,  0,  2'b00, 0, 2'b00, 0, 2'b00, 0,  0,  0,  0);
        add(2'b11, 0, 0, 0, 2'b00, 0,  0,  2'b01, 0, 2'b00, 0, 2'b00, 0,  0,  0,  0);
        add(2'b00, 0, 0, 0, 2'b00, 0,  0,  2'b00, 1, 2'b00, 0, 2'b01, D0, S0, 0,  0);
        add(2'b00, 0, 0, 1, 2'b01, Q0, R0, 2'b00, 0, 2'b01, 1, 2'b01, D0, S0, Q0, R0);
        add(2'b00, 0, 0, 0, 2'b00, Q0, R0, 2'b00, 0, 2'b00, 0, 2'b00, 0,  0,  0,  0);
        add(2'b11, 0, 0, 0, 2'b00, 0,  0,  2'b10, 0, 2'b00, 0, 2'b00, 0,  0,  0,  0);

        idle0 = '{valid: 2'b00, fl: 0, busy: 0, endv: 0, rspr: 2'b00, q: 0, r: 0,
                  e_ready: 2'b00, e_start: 0, e_rspv: 2'b00, e_endr: 0, e_ctl: 2'b00,
                  e_dvd: 0, e_dvs: 0, e_q: 0, e_r: 0};

        req_divw     = 2'b10;
        req_signed   = 2'b11;
        req_dividend = {D1, D0};
        req_divisor  = {S1, S0};
        rst_n        = 1'b0;
        drive(idle0);
        req_valid    = 2'b11;
        div_end_valid = 1'b1;
        rsp_ready    = 2'b11;
        #1;
        chk_all("reset", idle0);

        repeat (2) @(negedge clk);
        drive(idle0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Last vector accepted requester 1; it is now in ISSUE with a start pending.
        @(negedge clk);
        drive(idle0);
        #1;
        n_vec++;
        chk("pre-reset div_start", 64'(div_start), 64'd1);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk_all("async reset", idle0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_all($sformatf("post-reset%0d", i), idle0);
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        n_vec++;
        chk("post-reset grant", 64'(req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
